pc_trace_checker: RTL

- Synthesizable, parametrised on-chip checker for the Simple RISC Machine.
- Snoops the CPU program counter and the memory write bus, and compares each PC change and each store against a preloaded expected-trace table.
- Confirms HALT by requiring a stable PC, then reports pass or fail with an index and a cause code.
- Sits beside the CPU and MEM in the top level, so the same program check can run on the board and in simulation. The table has DEPTH entries instead of a fixed five-step sequence, and store checking is per step.

---
 rtl/pc_trace_checker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pc_trace_checker.sv
// pc_trace_checker: snoops the CPU PC and store bus, compares every PC change
// and store against a preloaded expected-trace table, then confirms HALT.
module pc_trace_checker #(
  parameter int PC_W     = 9,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int HALT_CYC = 32,
  parameter int TIMEOUT  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   exp_count,
  input  logic                     tbl_we,
  input  logic [$clog2(DEPTH)-1:0] tbl_idx,
  input  logic [PC_W-1:0]          tbl_pc,
  input  logic                     tbl_st,
  input  logic [PC_W-1:0]          tbl_st_addr,
  input  logic [DATA_W-1:0]        tbl_st_data,
  input  logic [PC_W-1:0]          pc,
  input  logic                     mem_write,
  input  logic [PC_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]        mem_din,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [$clog2(DEPTH):0]   step_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HALT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HALT_MAX  = HW'(HALT_CYC - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_HALT, S_PASS, S_FAIL} state_t;

  state_t state, state_d;

  logic [PC_W-1:0]   tpc_m   [DEPTH];
  logic              tst_m   [DEPTH];
  logic [PC_W-1:0]   taddr_m [DEPTH];
  logic [DATA_W-1:0] tdata_m [DEPTH];

  logic [PC_W-1:0]   pc_q;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     exp_q;
  logic [TW-1:0]     timer;
  logic [HW-1:0]     hcnt;
  logic              st_seen, st_multi;
  logic [PC_W-1:0]   st_addr_q;
  logic [DATA_W-1:0] st_data_q;

  logic              go, pc_ev, pc_ok, st_ok, last;
  logic              eff_seen, eff_multi;
  logic [PC_W-1:0]   eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic [1:0]        fail_d;

  // NOTE: the table is deliberately left out of reset so a program survives a board reset.
  always_ff @(posedge clk) begin
    if (tbl_we && state == S_IDLE) begin
      tpc_m[tbl_idx]   <= tbl_pc;
      tst_m[tbl_idx]   <= tbl_st;
      taddr_m[tbl_idx] <= tbl_st_addr;
      tdata_m[tbl_idx] <= tbl_st_data;
    end
  end

  assign go    = start && (state == S_IDLE || state == S_PASS || state == S_FAIL);
  assign pc_ev = (pc != pc_q);

  // A store in the event cycle itself is credited to the interval the event closes.
  assign eff_seen  = st_seen | mem_write;
  assign eff_multi = st_multi | (st_seen & mem_write);
  assign eff_addr  = st_seen ? st_addr_q : mem_addr;
  assign eff_data  = st_seen ? st_data_q : mem_din;

  assign pc_ok = (pc == tpc_m[idx]);
  assign st_ok = tst_m[idx] ? (eff_seen && !eff_multi && eff_addr == taddr_m[idx] &&
                               eff_data == tdata_m[idx])
                            : !eff_seen;
  assign last  = (({1'b0, idx} + CW'(1)) == exp_q);

  // NOTE: every register, including the state, uses non-blocking assignment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state;
    fail_d  = 2'd0;
    unique case (state)
      S_IDLE, S_PASS, S_FAIL: if (start) state_d = S_RUN;
      S_RUN: begin
        if (pc_ev) begin
          if (!pc_ok) begin
            state_d = S_FAIL;
            fail_d  = 2'd1;
          end else if (!st_ok) begin
            state_d = S_FAIL;
            fail_d  = 2'd2;
          end else if (last) begin
            state_d = S_HALT;
          end
        end else if (timer == TIMER_MAX) begin
          state_d = S_FAIL;
          fail_d  = 2'd3;
        end
      end
      S_HALT: begin
        if (pc_ev || mem_write) begin
          state_d = S_FAIL;
          fail_d  = 2'd3;
        end else if (hcnt == HALT_MAX) begin
          state_d = S_PASS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      idx        <= '0;
      exp_q      <= '0;
      timer      <= '0;
      hcnt       <= '0;
      st_seen    <= 1'b0;
      st_multi   <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      step_count <= '0;
      fail_code  <= '0;
      fail_idx   <= '0;
    end else begin
      pc_q <= pc;
      if (go) begin
        exp_q      <= (exp_count == '0 || exp_count > DEPTH_C) ? DEPTH_C : exp_count;
        idx        <= '0;
        timer      <= '0;
        hcnt       <= '0;
        st_seen    <= 1'b0;
        st_multi   <= 1'b0;
        step_count <= '0;
        fail_code  <= '0;
        fail_idx   <= '0;
      end else begin
        hcnt <= (state == S_HALT) ? hcnt + HW'(1) : '0;
        if (state == S_RUN) begin
          if (pc_ev) begin
            if (pc_ok && st_ok) begin
              step_count <= step_count + CW'(1);
              if (!last) idx <= idx + IW'(1);
              timer    <= '0;
              st_seen  <= 1'b0;
              st_multi <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
            if (mem_write) begin
              if (st_seen) begin
                st_multi <= 1'b1;
              end else begin
                st_seen   <= 1'b1;
                st_addr_q <= mem_addr;
                st_data_q <= mem_din;
              end
            end
          end
        end
        if (state_d == S_FAIL && state != S_FAIL) begin
          fail_code <= fail_d;
          fail_idx  <= idx;
        end
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_HALT);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule
